// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the Z80 bus master
package z80_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } bus_state_t;

    typedef enum logic [1:0] {
        MEM_RD    = 2'd0,
        MEM_WR    = 2'd1,
        OP_FETCH  = 2'd2,
        KIND_RSVD = 2'd3
    } req_kind_t;

    // Upper address byte presented during the refresh state.
    localparam logic [7:0] REFRESH_HI = 8'h00;

endpackage

// File: rtl/z80_bus_master.sv
// rtl/z80_bus_master.sv - Z80-style memory bus master with wait states and refresh
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter bit REFRESH_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        MREQ_L,
    output logic        RD_L,
    output logic        WR_L,
    output logic        M1_L,
    output logic        RFSH_L,
    input  logic        WAIT_L,
    inout  wire  [15:0] addr_bus,
    inout  wire  [7:0]  data_bus
);

    bus_state_t  state;
    bus_state_t  next_state;
    req_kind_t   kind_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  r_reg;
    logic [7:0]  rd_hold;
    logic        rd_pend;

    logic        is_write;
    logic        is_fetch;
    logic        in_cycle;
    logic        addr_oe;
    logic        data_oe;
    logic [15:0] addr_drive;

    assign is_write  = (kind_q == MEM_WR);
    assign is_fetch  = (kind_q == OP_FETCH);
    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (req_valid) next_state = T1;
            T1:      next_state = T2;
            T2, TW:  next_state = WAIT_L ? T3 : TW;
            T3:      next_state = (REFRESH_EN && is_fetch) ? T4 : IDLE;
            T4:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_cycle   = 1'b0;
        MREQ_L     = 1'b1;
        RD_L       = 1'b1;
        WR_L       = 1'b1;
        M1_L       = 1'b1;
        RFSH_L     = 1'b1;
        addr_oe    = 1'b0;
        data_oe    = 1'b0;
        addr_drive = addr_q;
        if (state inside {T1, T2, TW, T3}) in_cycle = 1'b1;
        if (in_cycle) begin
            MREQ_L  = 1'b0;
            addr_oe = 1'b1;
            if (is_write) begin
                data_oe = 1'b1;
                // Write strobe waits one state so data settles before WR_L falls.
                if (state != T1) WR_L = 1'b0;
            end else begin
                RD_L = 1'b0;
                M1_L = !is_fetch;
            end
        end
        if (state == T4) begin
            MREQ_L     = 1'b0;
            RFSH_L     = 1'b0;
            addr_oe    = 1'b1;
            addr_drive = {REFRESH_HI, r_reg};
        end
    end

    assign addr_bus = addr_oe ? addr_drive : 16'hzzzz;
    assign data_bus = data_oe ? wdata_q : 8'hzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kind_q    <= MEM_RD;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            r_reg     <= 8'h00;
            rd_hold   <= 8'h00;
            rd_pend   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                kind_q  <= (req_kind == 2'd3) ? MEM_RD : req_kind_t'(req_kind);
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Data is captured leaving T3 and presented one cycle later.
            rd_pend <= (state == T3) && !is_write;
            if (state == T3 && !is_write) rd_hold <= data_bus;
            rsp_valid <= rd_pend;
            if (rd_pend) rsp_rdata <= rd_hold;
            if (state == T4) r_reg <= {r_reg[7], r_reg[6:0] + 7'd1};
        end
    end

endmodule

// File: tb/tb_z80_bus_master.sv
// tb/tb_z80_bus_master.sv - scoreboard bench for z80_bus_master
module tb_z80_bus_master;
    import z80_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_kind = 2'd0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        WAIT_L = 1'b1;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        MREQ_L, RD_L, WR_L, M1_L, RFSH_L;
    wire  [15:0] addr_bus;
    wire  [7:0]  data_bus;

    z80_bus_master #(.REFRESH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .MREQ_L(MREQ_L), .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L),
        .WAIT_L(WAIT_L), .addr_bus(addr_bus), .data_bus(data_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign data_bus = (!MREQ_L && !RD_L) ? mem[addr_bus[7:0]] : 8'hzz;
    always @(posedge clk) if (!MREQ_L && !WR_L) mem[addr_bus[7:0]] <= data_bus;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got data %0h with nothing expected (cycle %0d)", rsp_rdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, mon_e.data});
                check("rsp_cycle", cyc, mon_e.at);
            end
        end
    end

    int c_mreq = 0, c_rd = 0, c_wr = 0, c_m1 = 0, c_rfsh = 0;
    logic [15:0] rfsh_addr = 16'hFFFF;
    always @(negedge clk) begin
        if (!MREQ_L) c_mreq++;
        if (!RD_L)   c_rd++;
        if (!WR_L)   c_wr++;
        if (!M1_L)   c_m1++;
        if (!RFSH_L) begin
            c_rfsh++;
            rfsh_addr = addr_bus;
        end
    end

    int w_from = 0, w_to = -1;
    always @(negedge clk) WAIT_L = !(cyc >= w_from && cyc <= w_to);

    task automatic clear_counts();
        c_mreq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rfsh = 0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_d, input int nwait, input bit hold, output int acc);
        int t = 0;
        req_valid = 1'b1;
        req_kind  = kind;
        req_addr  = addr;
        req_wdata = wd;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no req_ready want 1 within 50 cycles");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (nwait > 0) begin
            w_from = acc + 1;
            w_to   = acc + nwait;
        end
        if (kind != 2'd1) exp_q.push_back('{exp_d, acc + 4 + nwait});
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'h2A;
        mem[8'h0A] = 8'hED;
        mem[8'h55] = 8'h33;
        mem[8'h10] = 8'h5C;
        mem[8'hA0] = 8'h01;
        mem[8'hA1] = 8'h82;
        mem[8'hA2] = 8'hC3;

        repeat (3) @(negedge clk);
        check("rst_strobes", {27'h0, MREQ_L, RD_L, WR_L, M1_L, RFSH_L}, 32'h1F);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Zero-wait read, accepted at the first edge after reset release.
        clear_counts();
        issue(2'd0, 16'h0000, 8'h00, 8'h2A, 0, 1'b0, a0);
        repeat (6) @(negedge clk);
        check("rd_mreq_cycles", c_mreq, 3);
        check("rd_rd_cycles", c_rd, 3);
        check("rd_wr_cycles", c_wr, 0);
        check("rd_m1_cycles", c_m1, 0);

        // Write then read back.
        clear_counts();
        issue(2'd1, 16'h00BB, 8'hEF, 8'h00, 0, 1'b0, a0);
        repeat (5) @(negedge clk);
        check("wr_wr_cycles", c_wr, 2);
        check("wr_mreq_cycles", c_mreq, 3);
        check("wr_rd_cycles", c_rd, 0);
        issue(2'd0, 16'h00BB, 8'h00, 8'hEF, 0, 1'b0, a0);
        repeat (6) @(negedge clk);

        // Reserved kind behaves as a read.
        clear_counts();
        issue(2'd3, 16'h0000, 8'h00, 8'h2A, 0, 1'b0, a0);
        repeat (6) @(negedge clk);
        check("rsvd_rd_cycles", c_rd, 3);

        // Walk the refresh counter up to 8'h7F.
        for (int i = 0; i < 127; i++) begin
            issue(2'd2, 16'h000A, 8'h00, 8'hED, 0, 1'b0, a0);
            repeat (5) @(negedge clk);
            if (i == 0 || i == 126) check("rfsh_seq", {16'h0, rfsh_addr}, 32'(i));
        end
        clear_counts();
        issue(2'd2, 16'h000A, 8'h00, 8'hED, 0, 1'b0, a0);
        repeat (5) @(negedge clk);
        check("fetch_m1_cycles", c_m1, 3);
        check("fetch_rfsh_cycles", c_rfsh, 1);
        check("fetch_mreq_cycles", c_mreq, 4);
        check("fetch_rfsh_addr", {16'h0, rfsh_addr}, 32'h007F);
        issue(2'd2, 16'h000A, 8'h00, 8'hED, 0, 1'b0, a0);
        repeat (5) @(negedge clk);
        check("r_reg_wrap", {16'h0, rfsh_addr}, 32'h0000);

        // Three wait states inserted from T2.
        clear_counts();
        issue(2'd0, 16'h0010, 8'h00, 8'h5C, 3, 1'b0, a0);
        repeat (10) @(negedge clk);
        check("wait_rd_cycles", c_rd, 6);
        check("wait_mreq_cycles", c_mreq, 6);

        // Reset in T2 of a write aborts it.
        issue(2'd1, 16'h0055, 8'h11, 8'h00, 0, 1'b0, a0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_strobes", {27'h0, MREQ_L, RD_L, WR_L, M1_L, RFSH_L}, 32'h1F);
        check("abort_req_ready", {31'h0, req_ready}, 32'h0);
        check("abort_rsp_rdata", {24'h0, rsp_rdata}, 32'h0);
        repeat (2) @(negedge clk);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b0;
        #1;
        check("abort_ready_release", {31'h0, req_ready}, 32'h1);
        issue(2'd0, 16'h0055, 8'h00, 8'h33, 0, 1'b0, a0);
        repeat (6) @(negedge clk);
        issue(2'd2, 16'h000A, 8'h00, 8'hED, 0, 1'b0, a0);
        repeat (5) @(negedge clk);
        check("abort_r_reg_reset", {16'h0, rfsh_addr}, 32'h0000);

        // req_valid held across three reads.
        clear_counts();
        issue(2'd0, 16'h00A0, 8'h00, 8'h01, 0, 1'b1, a0);
        issue(2'd0, 16'h00A1, 8'h00, 8'h82, 0, 1'b1, a1);
        issue(2'd0, 16'h00A2, 8'h00, 8'hC3, 0, 1'b0, a2);
        repeat (6) @(negedge clk);
        check("b2b_gap1", a1 - a0, 4);
        check("b2b_gap2", a2 - a1, 4);
        check("b2b_rd_cycles", c_rd, 9);

        repeat (10) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_master.md
Z80_BUS_MASTER -- requirements
Module: z80_bus_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, exactly as named below.
REQ-002 Parameter REFRESH_EN, default 1: enables the refresh T4 state of opcode fetches.
REQ-003 clk  in  1  system clock; all state changes on posedge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 req_valid  in  1  core requests a bus cycle.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 req_kind  in  2  request type: MEM_RD=0, MEM_WR=1, OP_FETCH=2 (3 reserved, treated as MEM_RD).
REQ-008 req_addr  in  16  request address. req_wdata  in  8  write data.
REQ-009 rsp_valid  out  1  one-cycle pulse when read or fetch data is returned.
REQ-010 rsp_rdata  out  8  returned data, held until the next response.
REQ-011 MREQ_L, RD_L, WR_L, M1_L, RFSH_L  out  1 each  active-low bus strobes.
REQ-012 WAIT_L  in  1  active-low wait request from the responder.
REQ-013 addr_bus  inout  16; data_bus  inout  8: tristate shared buses.

Function
REQ-014 States SHALL be IDLE, T1, T2, TW, T3, T4.
REQ-015 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted when req_valid and req_ready are both 1 at a posedge, and kind, addr and wdata are registered at that edge.
REQ-016 Transitions: IDLE->T1 on accept; T1->T2; T2->TW if WAIT_L=0, else T3; TW->TW while WAIT_L=0, else T3; T3->T4 if OP_FETCH and REFRESH_EN, else IDLE; T4->IDLE.
REQ-017 In T1, T2, TW and T3, addr_bus SHALL drive the registered address and MREQ_L SHALL be 0; in IDLE addr_bus SHALL be z.
REQ-018 Read/fetch: RD_L=0 in T1, T2, TW and T3; M1_L=0 in the same states for OP_FETCH only.
REQ-019 Write: data_bus SHALL drive wdata in T1 through T3, with WR_L=0 in T2, TW and T3 only; data_bus SHALL be z in every other state and for reads.
REQ-020 Read data SHALL be sampled from data_bus at the posedge that leaves T3; rsp_valid=1 for exactly the following cycle.
REQ-021 Zero-wait read latency: accept at edge k -> rsp_valid high between edges k+4 and k+5.
REQ-022 Writes SHALL produce no rsp_valid.
REQ-023 T4 (refresh): addr_bus = {8'h00, r_reg}; MREQ_L=0, RFSH_L=0; RD_L, WR_L and M1_L all 1.
REQ-024 r_reg (8 bits) SHALL increment its low 7 bits modulo 128 on leaving T4, leaving bit 7 unchanged; 8'h7F -> 8'h00.
REQ-025 Back-to-back requests SHALL have at least one IDLE cycle between bus cycles; a req_valid held during a cycle waits.
REQ-026 WAIT_L SHALL be ignored outside T2 and TW; an unbounded WAIT_L=0 holds TW indefinitely.

Reset
REQ-027 While rst=1, the block SHALL hold: state IDLE; all strobes 1; addr_bus and data_bus z; req_ready 0; rsp_valid 0; rsp_rdata 8'h00; r_reg 8'h00.
REQ-028 Reset asserted mid-cycle SHALL abort the cycle immediately, with no response and no r_reg increment.
REQ-029 The first accept SHALL be possible at the first posedge after rst deasserts.

Structure
REQ-030 Package z80_bus_pkg SHALL hold: typedef enum bus_state_t (IDLE..T4); typedef enum req_kind_t; constant REFRESH_HI = 8'h00.
REQ-031 The block SHALL be a single module with no sub-module; tristate drivers SHALL be continuous assigns from registered enables.

Verification
REQ-032 Read addr 16'h0000, memory holds 8'h2A, WAIT_L=1 -> MREQ_L/RD_L low for 3 cycles, rsp_valid 4 cycles after accept, rsp_rdata=8'h2A.
REQ-033 Write addr 16'h00BB, data 8'hEF -> WR_L low for 2 cycles; a subsequent read of 16'h00BB returns 8'hEF.
REQ-034 OP_FETCH addr 16'h000A, memory holds 8'hED, r_reg=8'h7F -> M1_L low in T1-T3, T4 drives 16'h007F with RFSH_L=0; r_reg then 8'h00; rsp_rdata=8'hED.
REQ-035 Read with WAIT_L=0 for 3 cycles from T2 -> exactly 3 TW states; rsp_valid at accept+7.
REQ-036 rst pulsed during T2 of a write -> strobes 1 and buses z while rst=1; no response; req_ready=1 after release.
REQ-037 req_valid held high for 3 reads -> each read is accepted only in IDLE, with a 1-cycle gap between bus cycles.
